// File: rtl/csr_trap_ctrl_if.sv
// Core/CSR-file side bundle of the trap controller.
// The master is the core plus the CSR file, which drive the requests, the taps and csr_ready.
// The slave is the trap controller, which drives the CSR write port and the front-end controls.
interface csr_trap_ctrl_if;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [31:0] exc_pc;
    logic [31:0] exc_tval;
    logic        irq_ext;
    logic        mret_valid;
    logic [31:0] csr_mstatus;
    logic [31:0] csr_mie;
    logic [31:0] csr_mtvec;
    logic [31:0] csr_mepc;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        csr_ready;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output exc_valid, exc_cause, exc_pc, exc_tval, irq_ext, mret_valid,
        output csr_mstatus, csr_mie, csr_mtvec, csr_mepc, csr_ready,
        input  csr_we, csr_waddr, csr_wdata, stall, redirect_valid, redirect_pc
    );

    modport slave (
        input  exc_valid, exc_cause, exc_pc, exc_tval, irq_ext, mret_valid,
        input  csr_mstatus, csr_mie, csr_mtvec, csr_mepc, csr_ready,
        output csr_we, csr_waddr, csr_wdata, stall, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap/MRET sequencer.
// When a request is accepted, the controller snapshots every CSR value it needs.
// It then walks the CSR write port one register at a time and finishes with a one-cycle PC redirect.
// All outputs are flops that are decoded from the next state, so the interface sees no combinational paths.
module csr_trap_ctrl (
    input  logic           clk,
    input  logic           rst,
    csr_trap_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        W_MEPC    = 3'd1,
        W_MCAUSE  = 3'd2,
        W_MTVAL   = 3'd3,
        W_MSTATUS = 3'd4,
        REDIRECT  = 3'd5,
        R_MSTATUS = 3'd6
    } state_e;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;
    localparam logic [31:0] IRQ_CAUSE    = 32'h8000_000B;
    // Vectored-mode offset of the machine external interrupt: 4 * 11.
    localparam logic [31:0] IRQ_VEC_OFS  = 32'd44;

    // mstatus on trap entry: MPIE <= MIE, MIE <= 0, MPP <= M.
    function automatic logic [31:0] mstatus_on_trap(input logic [31:0] ms);
        logic [31:0] r;
        r       = ms;
        r[7]    = ms[3];
        r[3]    = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // mstatus on MRET: MIE <= MPIE, MPIE <= 1, MPP held at M.
    function automatic logic [31:0] mstatus_on_mret(input logic [31:0] ms);
        logic [31:0] r;
        r       = ms;
        r[3]    = ms[7];
        r[7]    = 1'b1;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // Redirect target selection.
    // Only an interrupt honours vectored mode, and the add wraps modulo 2^32.
    function automatic logic [31:0] redirect_target(input logic        is_mret,
                                                    input logic        is_irq,
                                                    input logic [31:0] mtvec,
                                                    input logic [31:0] mepc);
        logic [31:0] base;
        base = {mtvec[31:2], 2'b00};
        if (is_mret) begin
            return {mepc[31:2], 2'b00};
        end else if (is_irq && (mtvec[1:0] == 2'b01)) begin
            return base + IRQ_VEC_OFS;
        end else begin
            return base;
        end
    endfunction

    state_e      state_q, state_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] tval_q, tval_d;
    logic [31:0] mstatus_new_q, mstatus_new_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mepc_q, mepc_d;
    logic        is_irq_q, is_irq_d;
    logic        is_mret_q, is_mret_d;

    logic        csr_we_q, csr_we_d;
    logic [11:0] csr_waddr_q, csr_waddr_d;
    logic [31:0] csr_wdata_q, csr_wdata_d;
    logic        stall_q, stall_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic        irq_req_s;

    // Interrupt is pending only when globally enabled (MIE) and locally enabled (MEIE).
    always_comb begin
        irq_req_s = bus.irq_ext & bus.csr_mstatus[3] & bus.csr_mie[11];
    end

    // Next-state logic and snapshot capture; taps are only sampled in IDLE.
    always_comb begin
        state_d       = state_q;
        epc_d         = epc_q;
        cause_d       = cause_q;
        tval_d        = tval_q;
        mstatus_new_d = mstatus_new_q;
        mtvec_d       = mtvec_q;
        mepc_d        = mepc_q;
        is_irq_d      = is_irq_q;
        is_mret_d     = is_mret_q;

        case (state_q)
            IDLE: begin
                if (bus.exc_valid) begin
                    epc_d         = bus.exc_pc;
                    cause_d       = {28'd0, bus.exc_cause};
                    tval_d        = bus.exc_tval;
                    mstatus_new_d = mstatus_on_trap(bus.csr_mstatus);
                    mtvec_d       = bus.csr_mtvec;
                    is_irq_d      = 1'b0;
                    is_mret_d     = 1'b0;
                    state_d       = W_MEPC;
                end else if (irq_req_s) begin
                    // The core presents the resume PC on exc_pc for interrupts.
                    epc_d         = bus.exc_pc;
                    cause_d       = IRQ_CAUSE;
                    tval_d        = 32'd0;
                    mstatus_new_d = mstatus_on_trap(bus.csr_mstatus);
                    mtvec_d       = bus.csr_mtvec;
                    is_irq_d      = 1'b1;
                    is_mret_d     = 1'b0;
                    state_d       = W_MEPC;
                end else if (bus.mret_valid) begin
                    mstatus_new_d = mstatus_on_mret(bus.csr_mstatus);
                    mepc_d        = bus.csr_mepc;
                    is_irq_d      = 1'b0;
                    is_mret_d     = 1'b1;
                    state_d       = R_MSTATUS;
                end else begin
                    state_d = IDLE;
                end
            end
            W_MEPC: begin
                if (bus.csr_ready) begin
                    state_d = W_MCAUSE;
                end else begin
                    state_d = W_MEPC;
                end
            end
            W_MCAUSE: begin
                if (bus.csr_ready) begin
                    state_d = W_MTVAL;
                end else begin
                    state_d = W_MCAUSE;
                end
            end
            W_MTVAL: begin
                if (bus.csr_ready) begin
                    state_d = W_MSTATUS;
                end else begin
                    state_d = W_MTVAL;
                end
            end
            W_MSTATUS: begin
                if (bus.csr_ready) begin
                    state_d = REDIRECT;
                end else begin
                    state_d = W_MSTATUS;
                end
            end
            R_MSTATUS: begin
                if (bus.csr_ready) begin
                    state_d = REDIRECT;
                end else begin
                    state_d = R_MSTATUS;
                end
            end
            REDIRECT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the next state, so the registered outputs line up with the state register.
    always_comb begin
        csr_we_d         = 1'b0;
        csr_waddr_d      = 12'd0;
        csr_wdata_d      = 32'd0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = 32'd0;
        stall_d          = (state_d != IDLE);

        case (state_d)
            W_MEPC: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = ADDR_MEPC;
                csr_wdata_d = epc_d & ~32'd3;
            end
            W_MCAUSE: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = ADDR_MCAUSE;
                csr_wdata_d = cause_d;
            end
            W_MTVAL: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = ADDR_MTVAL;
                csr_wdata_d = tval_d;
            end
            W_MSTATUS, R_MSTATUS: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = ADDR_MSTATUS;
                csr_wdata_d = mstatus_new_d;
            end
            REDIRECT: begin
                redirect_valid_d = 1'b1;
                redirect_pc_d    = redirect_target(is_mret_d, is_irq_d, mtvec_d, mepc_d);
            end
            IDLE: begin
                csr_we_d = 1'b0;
            end
            default: begin
                csr_we_d = 1'b0;
            end
        endcase
    end

    // State, snapshot and output registers; synchronous reset clears everything and aborts any sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            epc_q            <= 32'd0;
            cause_q          <= 32'd0;
            tval_q           <= 32'd0;
            mstatus_new_q    <= 32'd0;
            mtvec_q          <= 32'd0;
            mepc_q           <= 32'd0;
            is_irq_q         <= 1'b0;
            is_mret_q        <= 1'b0;
            csr_we_q         <= 1'b0;
            csr_waddr_q      <= 12'd0;
            csr_wdata_q      <= 32'd0;
            stall_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
        end else begin
            state_q          <= state_d;
            epc_q            <= epc_d;
            cause_q          <= cause_d;
            tval_q           <= tval_d;
            mstatus_new_q    <= mstatus_new_d;
            mtvec_q          <= mtvec_d;
            mepc_q           <= mepc_d;
            is_irq_q         <= is_irq_d;
            is_mret_q        <= is_mret_d;
            csr_we_q         <= csr_we_d;
            csr_waddr_q      <= csr_waddr_d;
            csr_wdata_q      <= csr_wdata_d;
            stall_q          <= stall_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign bus.csr_we         = csr_we_q;
    assign bus.csr_waddr      = csr_waddr_q;
    assign bus.csr_wdata      = csr_wdata_q;
    assign bus.stall          = stall_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Scoreboard bench for csr_trap_ctrl.
// Expected CSR writes and redirects are queued when a request is driven.
// A negedge monitor pops the queue and compares every write accepted by the CSR file and every redirect.
module tb_csr_trap_ctrl;

    typedef struct {
        bit          is_redir;
        logic [11:0] addr;
        logic [31:0] data;
        int          cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    ev_t  sb[$];

    csr_trap_ctrl_if bus();

    csr_trap_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Edge counter used to time redirects.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] f_trap_ms(input logic [31:0] m);
        return (m & 32'hFFFF_E777) | 32'h0000_1800 | {24'd0, m[3], 7'd0};
    endfunction

    function automatic logic [31:0] f_mret_ms(input logic [31:0] m);
        return (m & 32'hFFFF_E777) | 32'h0000_1880 | {28'd0, m[7], 3'd0};
    endfunction

    task automatic push(input bit r, input logic [11:0] a, input logic [31:0] d, input int c);
        ev_t e;
        e.is_redir = r;
        e.addr     = a;
        e.data     = d;
        e.cyc      = c;
        sb.push_back(e);
    endtask

    // Monitor: every accepted write and every redirect must match the head of the scoreboard.
    always @(negedge clk) begin
        ev_t e;
        if (bus.csr_we && bus.csr_ready) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_write", {20'd0, bus.csr_waddr}, 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("wr_kind", {31'd0, e.is_redir}, 32'd0);
                check_eq("wr_addr", {20'd0, bus.csr_waddr}, {20'd0, e.addr});
                check_eq("wr_data", bus.csr_wdata, e.data);
            end
        end
        if (bus.redirect_valid) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_redirect", bus.redirect_pc, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check_eq("rd_kind", {31'd0, e.is_redir}, 32'd1);
                check_eq("redirect_pc", bus.redirect_pc, e.data);
                check_eq("redirect_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic check_zero(input string tag);
        check_eq({tag, "_we"}, {31'd0, bus.csr_we}, 32'd0);
        check_eq({tag, "_stall"}, {31'd0, bus.stall}, 32'd0);
        check_eq({tag, "_rv"}, {31'd0, bus.redirect_valid}, 32'd0);
        check_eq({tag, "_waddr"}, {20'd0, bus.csr_waddr}, 32'd0);
        check_eq({tag, "_wdata"}, bus.csr_wdata, 32'd0);
        check_eq({tag, "_rpc"}, bus.redirect_pc, 32'd0);
    endtask

    // Waits (bounded) until every expected event was seen, then checks that stall has dropped.
    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check_eq("drain_timeout", sb.size(), 32'd0);
            sb.delete();
        end
        #1;
        check_eq("stall_idle", {31'd0, bus.stall}, 32'd0);
    endtask

    // Trap sequence.
    // mode 0: plain run.
    // mode 1: csr_ready is held low for 3 cycles in W_MCAUSE.
    // mode 2: all three requests are raised together, taps change after acceptance,
    //         and a second exception is raised during W_MTVAL.
    // mode 3: reset is asserted in W_MCAUSE.
    // Call this task at #1 after a clock edge.
    task automatic do_trap(input bit irq, input logic [3:0] cause, input logic [31:0] pc,
                           input logic [31:0] tval, input int mode);
        int          n;
        logic [31:0] base, tgt, cs, tv, ms;
        n    = cyc + 1;
        cs   = irq ? 32'h8000_000B : {28'd0, cause};
        tv   = irq ? 32'd0 : tval;
        ms   = f_trap_ms(bus.csr_mstatus);
        base = {bus.csr_mtvec[31:2], 2'b00};
        tgt  = (irq && bus.csr_mtvec[1:0] == 2'b01) ? base + 32'd44 : base;
        push(1'b0, 12'h341, pc & 32'hFFFF_FFFC, -1);
        if (mode != 3) begin
            push(1'b0, 12'h342, cs, -1);
            push(1'b0, 12'h343, tv, -1);
            push(1'b0, 12'h300, ms, -1);
            push(1'b1, 12'h000, tgt, n + 4 + ((mode == 1) ? 3 : 0));
        end
        bus.exc_cause = cause;
        bus.exc_pc    = pc;
        bus.exc_tval  = tval;
        if (irq) bus.irq_ext = 1'b1;
        else     bus.exc_valid = 1'b1;
        if (mode == 2) begin
            bus.exc_valid  = 1'b1;
            bus.irq_ext    = 1'b1;
            bus.mret_valid = 1'b1;
        end
        @(posedge clk); #1;
        bus.exc_valid  = 1'b0;
        bus.irq_ext    = 1'b0;
        bus.mret_valid = 1'b0;
        check_eq("stall_busy", {31'd0, bus.stall}, 32'd1);
        if (mode == 1) begin
            @(posedge clk); #1;
            bus.csr_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check_eq("bp_waddr", {20'd0, bus.csr_waddr}, 32'h342);
                check_eq("bp_wdata", bus.csr_wdata, cs);
                check_eq("bp_stall", {31'd0, bus.stall}, 32'd1);
                @(posedge clk); #1;
            end
            bus.csr_ready = 1'b1;
        end else if (mode == 2) begin
            bus.csr_mstatus = 32'd0;
            bus.csr_mtvec   = 32'h0000_FFF0;
            bus.csr_mepc    = 32'h0000_4444;
            @(posedge clk); #1;
            @(posedge clk); #1;
            bus.exc_valid = 1'b1;
            bus.exc_cause = 4'd7;
            bus.exc_pc    = 32'h0000_0BAD;
            @(posedge clk); #1;
            bus.exc_valid = 1'b0;
        end else if (mode == 3) begin
            @(posedge clk); #1;
            rst           = 1'b1;
            bus.csr_ready = 1'b0;
            @(posedge clk); #1;
            check_zero("rst_mid");
            @(posedge clk); #1;
            check_zero("rst_hold");
            check_eq("abort_sb", sb.size(), 32'd0);
            rst           = 1'b0;
            bus.csr_ready = 1'b1;
        end
        if (mode != 3) wait_drain();
    endtask

    task automatic do_mret();
        int n;
        n = cyc + 1;
        push(1'b0, 12'h300, f_mret_ms(bus.csr_mstatus), -1);
        push(1'b1, 12'h000, {bus.csr_mepc[31:2], 2'b00}, n + 1);
        bus.mret_valid = 1'b1;
        @(posedge clk); #1;
        bus.mret_valid = 1'b0;
        wait_drain();
    endtask

    // Global guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got 1, want 0");
        $fatal(1, "bench timeout");
    end

    initial begin
        bus.exc_valid   = 1'b0;
        bus.exc_cause   = 4'd0;
        bus.exc_pc      = 32'd0;
        bus.exc_tval    = 32'd0;
        bus.irq_ext     = 1'b0;
        bus.mret_valid  = 1'b0;
        bus.csr_mstatus = 32'd0;
        bus.csr_mie     = 32'd0;
        bus.csr_mtvec   = 32'd0;
        bus.csr_mepc    = 32'd0;
        bus.csr_ready   = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // Exception into direct-mode vector.
        bus.csr_mstatus = 32'h0000_0008;
        bus.csr_mtvec   = 32'h0000_0200;
        do_trap(1'b0, 4'd2, 32'h0000_0100, 32'h0000_DEAD, 0);

        // Vectored external interrupt.
        bus.csr_mstatus = 32'h0000_0008;
        bus.csr_mie     = 32'h0000_0800;
        bus.csr_mtvec   = 32'h0000_0201;
        do_trap(1'b1, 4'd0, 32'h1234_5677, 32'h5555_5555, 0);

        // Vectored offset wraps around 2^32.
        bus.csr_mtvec = 32'hFFFF_FFE1;
        do_trap(1'b1, 4'd0, 32'h0000_0040, 32'd0, 0);

        // Interrupt masked by MIE, then by MEIE: no action.
        bus.csr_mstatus = 32'h0000_0000;
        bus.irq_ext     = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_eq("irq_masked_mie", {31'd0, bus.stall}, 32'd0);
        end
        bus.csr_mstatus = 32'h0000_0008;
        bus.csr_mie     = 32'h0000_0000;
        repeat (3) begin
            @(negedge clk);
            check_eq("irq_masked_meie", {31'd0, bus.stall}, 32'd0);
        end
        @(posedge clk); #1;
        bus.irq_ext = 1'b0;

        // MRET.
        bus.csr_mstatus = 32'h0000_1880;
        bus.csr_mepc    = 32'h0000_0104;
        do_mret();
        bus.csr_mepc = 32'h8000_0007;
        do_mret();

        // Backpressure in W_MCAUSE.
        bus.csr_mstatus = 32'h0000_0008;
        bus.csr_mtvec   = 32'h0000_0200;
        do_trap(1'b0, 4'd5, 32'h0000_0304, 32'h0000_0011, 1);

        // Simultaneous requests; exception wins even with vectored mtvec.
        bus.csr_mstatus = 32'h0000_0008;
        bus.csr_mie     = 32'h0000_0800;
        bus.csr_mtvec   = 32'h0000_0301;
        bus.csr_mepc    = 32'h0000_0900;
        do_trap(1'b0, 4'd11, 32'h0000_0402, 32'h0000_0077, 2);

        // Reset in W_MCAUSE, then an exception on the first edge after reset.
        bus.csr_mstatus = 32'h0000_0008;
        bus.csr_mie     = 32'h0000_0000;
        bus.csr_mtvec   = 32'h0000_0200;
        do_trap(1'b0, 4'd3, 32'h0000_0500, 32'h0000_0123, 3);
        do_trap(1'b0, 4'd4, 32'h0000_0600, 32'h0000_0456, 0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
